// File: rtl/tx_serializer.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Optional parity bit enabled by defining TX_SERIALIZER_PARITY_EN.
module tx_serializer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              TxData,
  input  logic [DATA_W-1:0] DataIn,
  output logic              SerOut,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [DATA_W-1:0]  shift, shift_d;
  logic               armed, armed_d;
  logic               ser_d, busy_d, done_d;
  logic               bit_end;
`ifdef TX_SERIALIZER_PARITY_EN
  logic               parity, parity_d;
`endif

  assign bit_end = (cnt == CNT_LAST);

  // State and registered outputs; reset forces the line idle-high immediately
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      armed  <= 1'b0;
      SerOut <= 1'b1;
      TxBusy <= 1'b0;
      TxDone <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      shift  <= shift_d;
      armed  <= armed_d;
      SerOut <= ser_d;
      TxBusy <= busy_d;
      TxDone <= done_d;
`ifdef TX_SERIALIZER_PARITY_EN
      parity <= parity_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs reflect the state being entered
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    armed_d = armed | ~TxData;
    ser_d   = 1'b1;
    busy_d  = 1'b1;
    done_d  = 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
    parity_d = parity;
`endif

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        // A request only launches after TxData has been seen low at least once
        if (TxData && armed) begin
          state_d = START;
          shift_d = DataIn;
          armed_d = 1'b0;
          cnt_d   = '0;
          ser_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef TX_SERIALIZER_PARITY_EN
          parity_d = ^DataIn;
`endif
        end
      end
      START: begin
        ser_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
          ser_d   = shift[0];
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        ser_d = shift[0];
        if (bit_end) begin
          cnt_d = '0;
          if (idx == IDX_LAST) begin
`ifdef TX_SERIALIZER_PARITY_EN
            state_d = PARITY;
            ser_d   = parity;
`else
            state_d = STOP;
            ser_d   = 1'b1;
`endif
          end else begin
            shift_d = shift >> 1;
            idx_d   = idx + IDX_W'(1);
            ser_d   = shift_d[0];
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_d = parity;
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          ser_d   = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Serial transmitter that sits downstream of the read/write flow controller.
- Consumes the controller's TxData request and parallel word, and drives an asynchronous-style serial line: start bit, DATA_W data bits LSB first, stop bit.
- Returns a one-cycle TxDone pulse, which the controller uses to leave its transmit state.
- Provides the transmit end of the controller's TxData/TxDone handshake.

Parameters:
- DATA_W, 8, width of parallel word transmitted per frame (1..32).
- CLKS_PER_BIT, 16, Clk cycles per serial bit (>=2).
- CNT_W, 16, width of bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- Clk  input  1  single clock; all state changes on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- TxData  input  1  transmit request level from controller; held high until TxDone is seen.
- DataIn  input  DATA_W  word to send; sampled only on the frame-start edge.
- SerOut  output  1  serial line; idles high.
- TxBusy  output  1  high from frame start through DONE cycle inclusive.
- TxDone  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, SerOut=1, TxBusy=0, TxDone=0, shift reg=0, counters=0, armed=0.
- armed flag: set on any edge with TxData=0; cleared at frame start.
  - A request held high across TxDone never launches a second frame; TxData must drop low at least one cycle first.
- States: IDLE, START, DATA, [PARITY], STOP, DONE.
- IDLE:
  - SerOut=1, TxBusy=0.
  - On edge with TxData=1 and armed=1: latch DataIn into shift reg, clear armed, bit-period counter=0, go to START.
  - SerOut=0 and TxBusy=1 from that same edge (latency 1 cycle from sampled request).
- START: SerOut=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
- DATA:
  - SerOut=shift[0] for CLKS_PER_BIT cycles per bit; shift right at each bit boundary.
  - After bit DATA_W-1 go to STOP, or to PARITY when the optional feature is compiled in.
- STOP: SerOut=1 for CLKS_PER_BIT cycles, then DONE.
- DONE: exactly one cycle with TxDone=1, TxBusy=1, SerOut=1; then IDLE.
- Frame length, start edge to DONE edge: (DATA_W+2)*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
- Bit-period counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary; bit index counts 0..DATA_W-1.
- TxData dropping mid-frame is ignored; the frame always completes. TxData=1 during DONE with armed=0 does not restart.
- DataIn changes after the start edge do not affect the frame in flight.
- Reset_n asserted mid-frame: immediate return to reset values; SerOut=1 glitch-free in the same cycle; no TxDone emitted.
- TxDone and TxBusy are registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TX_SERIALIZER_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA for CLKS_PER_BIT cycles.
  - SerOut=even parity (XOR of the latched word, computed at start edge).
  - Frame = (DATA_W+3)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; frame = (DATA_W+2)*CLKS_PER_BIT cycles.

Test Plan (DATA_W=8, CLKS_PER_BIT=4):
- Basic frame: Reset_n low 3 cycles then high; TxData=0 for 2 cycles, then TxData=1 with DataIn=8'hA5.
  - SerOut=0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles.
  - TxDone single pulse 40 cycles after start edge; TxBusy high 41 cycles.
- Held request: TxData held high through and 10 cycles past TxDone -> no second start bit; SerOut stays 1, TxBusy=0 until TxData goes 0 then 1 again.
- Back-to-back: 8'h00 then 8'hFF with TxData low for exactly one cycle between -> second start bit begins 2 cycles after first TxDone; data bits all 0 then all 1.
- DataIn churn: DataIn changes every cycle after start edge of 8'h3C -> serial bits 0,0,1,1,1,1,0,0 unchanged.
- Mid-frame reset: Reset_n pulsed low at cycle 17 of a frame -> SerOut=1, TxBusy=0 same cycle; TxDone never pulses; next TxData low->high sends a clean frame.
- Parity (TX_SERIALIZER_PARITY_EN defined):
  - 8'hA5 -> parity bit 0.
  - 8'h07 -> parity bit 1.
  - TxDone 44 cycles after start edge.
